// File: rtl/intermed_wire_exerciser.sv
// intermed_wire_exerciser
//   Drives all eight {in_3,in_2,in_1} combinations into an intermed_wire
//   gate block. After a settle window it samples the block's two outputs
//   and compares them with a golden model:
//     out_1 = in_1 & in_2 & in_3
//     out_2 = (in_1 & in_2) | in_3
//   It reports a saturating error count, the first failing vector and a
//   pass flag.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   start             run request; only looked at while idle
//   busy              high from the cycle after start is accepted through DONE
//   done              one-cycle pulse in the final (DONE) cycle of a run
//   drv_in_1..3       registered drive to the block, bit 0..2 of the vector
//   obs_out_1/2       block outputs being checked
//   err_count         mismatching samples, saturating at 2^ERR_W-1
//   first_err_vec     vector of the first mismatch of the run
//   first_err_valid   first_err_vec holds a captured vector
//   pass              last completed run saw zero mismatches
module intermed_wire_exerciser #(
    parameter int NUM_PASSES    = 1,   // 1..255 full sweeps per run
    parameter int SETTLE_CYCLES = 1,   // 0..15 wait cycles before sampling
    parameter int ERR_W         = 8    // error counter width, >= 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             drv_in_1,
    output logic             drv_in_2,
    output logic             drv_in_3,
    input  logic             obs_out_1,
    input  logic             obs_out_2,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       first_err_vec,
    output logic             first_err_valid,
    output logic             pass
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // Last value the settle counter reaches before moving on to SAMPLE.
    // The counter is unused when SETTLE_CYCLES is 0.
    localparam logic [3:0]       SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [7:0]       PASS_LAST   = 8'(NUM_PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t           state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [7:0]       pass_cnt_q, pass_cnt_d;
    logic [3:0]       settle_cnt_q, settle_cnt_d;
    logic [2:0]       drv_q, drv_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [2:0]       fev_q, fev_d;
    logic             fev_vld_q, fev_vld_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic gold_1, gold_2, sample_bad;

    // The golden model is taken from the vector counter, not from the drive
    // register. Both hold the same value during SAMPLE, but the counter is
    // the authoritative copy.
    always_comb begin
        gold_1     = &vec_q;
        gold_2     = (vec_q[0] & vec_q[1]) | vec_q[2];
        sample_bad = (obs_out_1 != gold_1) || (obs_out_2 != gold_2);
    end

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        pass_cnt_d   = pass_cnt_q;
        settle_cnt_d = settle_cnt_q;
        drv_d        = drv_q;
        err_cnt_d    = err_cnt_q;
        fev_d        = fev_q;
        fev_vld_d    = fev_vld_q;
        pass_d       = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_DRIVE;
                    vec_d        = 3'd0;
                    pass_cnt_d   = 8'd0;
                    settle_cnt_d = 4'd0;
                    err_cnt_d    = '0;
                    fev_d        = 3'd0;
                    fev_vld_d    = 1'b0;
                    pass_d       = 1'b0;
                end
            end
            S_DRIVE: begin
                drv_d        = vec_q;
                settle_cnt_d = 4'd0;
                state_d      = (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
            end
            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                if (sample_bad) begin
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (!fev_vld_q) begin
                        fev_d     = vec_q;
                        fev_vld_d = 1'b1;
                    end
                end
                if (vec_q != 3'd7) begin
                    vec_d   = vec_q + 3'd1;
                    state_d = S_DRIVE;
                end else if (pass_cnt_q != PASS_LAST) begin
                    vec_d      = 3'd0;
                    pass_cnt_d = pass_cnt_q + 8'd1;
                    state_d    = S_DRIVE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // err_cnt_q already includes the final sample here.
                drv_d   = 3'd0;
                pass_d  = (err_cnt_q == '0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // busy and done are registered copies of the next state, so they
        // line up exactly with the state they describe.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vec_q        <= 3'd0;
            pass_cnt_q   <= 8'd0;
            settle_cnt_q <= 4'd0;
            drv_q        <= 3'd0;
            err_cnt_q    <= '0;
            fev_q        <= 3'd0;
            fev_vld_q    <= 1'b0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            pass_cnt_q   <= pass_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            drv_q        <= drv_d;
            err_cnt_q    <= err_cnt_d;
            fev_q        <= fev_d;
            fev_vld_q    <= fev_vld_d;
            pass_q       <= pass_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign drv_in_1        = drv_q[0];
    assign drv_in_2        = drv_q[1];
    assign drv_in_3        = drv_q[2];
    assign err_count       = err_cnt_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fev_vld_q;
    assign pass            = pass_q;

endmodule

// File: tb/tb_intermed_wire_exerciser.sv
// Bench for intermed_wire_exerciser. It uses two instances:
//   inst 0: NUM_PASSES=1, SETTLE_CYCLES=1, ERR_W=8
//   inst 1: NUM_PASSES=2, SETTLE_CYCLES=0, ERR_W=3
// The gate block under test is modelled in the bench. A per-instance fault
// mode can corrupt the block's outputs: clean or random flip table, out_1
// stuck at 0, or out_2 inverted. Expected results come from a
// vector-level model of the run.
module tb_intermed_wire_exerciser;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       start_v [2];
    logic       obs1    [2];
    logic       obs2    [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic [2:0] drv_w   [2];
    logic [7:0] err_w   [2];
    logic [2:0] fev_w   [2];
    logic       fevld_w [2];
    logic       pass_w  [2];

    int         mode    [2];      // 0 flip table, 1 out_1 stuck 0, 2 out_2 inverted
    logic [1:0] flip_t  [2][8];   // {out_2,out_1} flip mask per vector

    int n_chk  = 0;
    int n_pass = 0;

    logic d1_0, d2_0, d3_0, d1_1, d2_1, d3_1;
    logic [2:0] e1;

    intermed_wire_exerciser #(.NUM_PASSES(1), .SETTLE_CYCLES(1), .ERR_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_w[0]), .done(done_w[0]),
        .drv_in_1(d1_0), .drv_in_2(d2_0), .drv_in_3(d3_0),
        .obs_out_1(obs1[0]), .obs_out_2(obs2[0]),
        .err_count(err_w[0]), .first_err_vec(fev_w[0]),
        .first_err_valid(fevld_w[0]), .pass(pass_w[0]));

    intermed_wire_exerciser #(.NUM_PASSES(2), .SETTLE_CYCLES(0), .ERR_W(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_w[1]), .done(done_w[1]),
        .drv_in_1(d1_1), .drv_in_2(d2_1), .drv_in_3(d3_1),
        .obs_out_1(obs1[1]), .obs_out_2(obs2[1]),
        .err_count(e1), .first_err_vec(fev_w[1]),
        .first_err_valid(fevld_w[1]), .pass(pass_w[1]));

    assign drv_w[0] = {d3_0, d2_0, d1_0};
    assign drv_w[1] = {d3_1, d2_1, d1_1};
    assign err_w[1] = {5'd0, e1};

    // Gate block truth: {out_2, out_1}
    function automatic logic [1:0] golden(input logic [2:0] v);
        return {(v[0] & v[1]) | v[2], v[0] & v[1] & v[2]};
    endfunction

    function automatic logic [1:0] faulty(input int i, input logic [2:0] v);
        logic [1:0] g;
        g = golden(v);
        case (mode[i])
            1:       return {g[1], 1'b0};
            2:       return {~g[1], g[0]};
            default: return g ^ flip_t[i][v];
        endcase
    endfunction

    logic [1:0] o0, o1;
    always_comb begin
        o0 = faulty(0, drv_w[0]);
        o1 = faulty(1, drv_w[1]);
        obs1[0] = o0[0];
        obs2[0] = o0[1];
        obs1[1] = o1[0];
        obs2[1] = o1[1];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int n_passes(input int i);
        return (i == 0) ? 1 : 2;
    endfunction
    function automatic int settle(input int i);
        return (i == 0) ? 1 : 0;
    endfunction
    function automatic int err_max(input int i);
        return (i == 0) ? 255 : 7;
    endfunction

    task automatic clear_faults(input int i, input int m);
        mode[i] = m;
        for (int v = 0; v < 8; v++) flip_t[i][v] = 2'b00;
    endtask

    // One full run. Accept the start, then check every cycle up to DONE
    // and the results in the following idle cycle. repulse: cycle at
    // which start is pulsed again (0 means none). hold: leave start high.
    task automatic run(input int i, input int repulse, input bit hold);
        int L, T, nbad, exp_err, first;
        logic [31:0] exp_drv;
        L = 2 + settle(i);
        T = 1 + 8 * n_passes(i) * L;
        nbad = 0;
        first = -1;
        for (int v = 0; v < 8; v++) begin
            if (faulty(i, 3'(v)) != golden(3'(v))) begin
                nbad++;
                if (first < 0) first = v;
            end
        end
        exp_err = nbad * n_passes(i);
        if (exp_err > err_max(i)) exp_err = err_max(i);

        start_v[i] = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_v[i] = 1'b0;
        for (int k = 1; k <= T; k++) begin
            chk("busy", busy_w[i], 1);
            chk("done", done_w[i], (k == T) ? 1 : 0);
            exp_drv = (k == 1) ? 0 : ((k - 2) / L) % 8;
            chk("drv", drv_w[i], exp_drv);
            if (k == 1) begin
                chk("clr_err", err_w[i], 0);
                chk("clr_fevld", fevld_w[i], 0);
                chk("clr_pass", pass_w[i], 0);
            end
            if (repulse != 0 && k == repulse) start_v[i] = 1'b1;
            if (repulse != 0 && k == repulse + 1) start_v[i] = 1'b0;
            @(posedge clk); #1;
        end
        chk("end_busy", busy_w[i], 0);
        chk("end_done", done_w[i], 0);
        chk("end_drv", drv_w[i], 0);
        chk("err_count", err_w[i], exp_err);
        chk("first_err_valid", fevld_w[i], (first >= 0) ? 1 : 0);
        chk("first_err_vec", fev_w[i], (first >= 0) ? first : 0);
        chk("pass", pass_w[i], (nbad == 0) ? 1 : 0);
    endtask

    task automatic check_reset_vals(input int i);
        chk("rst_busy", busy_w[i], 0);
        chk("rst_done", done_w[i], 0);
        chk("rst_drv", drv_w[i], 0);
        chk("rst_err", err_w[i], 0);
        chk("rst_fev", fev_w[i], 0);
        chk("rst_fevld", fevld_w[i], 0);
        chk("rst_pass", pass_w[i], 0);
    endtask

    initial begin
        int guard;
        logic [31:0] hold_err;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        clear_faults(0, 0);
        clear_faults(1, 0);

        // Asynchronous reset: outputs clear before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals(0);
        check_reset_vals(1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean loopback on both instances
        run(0, 0, 0);
        run(1, 0, 0);

        // out_1 stuck at 0 -> only vector 7 fails
        clear_faults(0, 1);
        run(0, 0, 0);
        // Results hold while idle
        hold_err = err_w[0];
        repeat (4) @(posedge clk);
        #1;
        chk("hold_err", err_w[0], hold_err);
        chk("hold_fev", fev_w[0], 7);

        // out_2 inverted over two passes -> saturates at 7
        clear_faults(1, 2);
        run(1, 0, 0);

        // start re-pulsed mid-run is ignored
        clear_faults(0, 0);
        run(0, 5, 0);

        // Reset mid-run while vector 4 is on the drive lines
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        guard = 0;
        while (drv_w[0] != 3'd4 && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reach_vec4", (guard < 60) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals(0);
        @(posedge clk); #1;
        chk("abort_done", done_w[0], 0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("abort_idle_done", done_w[0], 0);
        end
        run(0, 0, 0);

        // Back-to-back runs with start held high
        run(0, 0, 1);
        for (int v = 0; v < 8; v++) flip_t[0][v] = (v == 3) ? 2'b10 : 2'b00;
        run(0, 0, 0);

        // Randomized fault tables
        for (int r = 0; r < 8; r++) begin
            int i;
            i = r % 2;
            mode[i] = 0;
            for (int v = 0; v < 8; v++)
                flip_t[i][v] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run(i, 0, 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
